tpbuf_pingpong: RTL and testbench
=================================

TPBUF_PINGPONG -- requirements
Module: tpbuf_pingpong

Interface
REQ-001 Parameter N, default 8, block dimension (rows = columns = elements per row); legal 2..16.
REQ-002 Parameter W, default 8, element width in bits; legal 1..32.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous flush; discards all buffered data.
REQ-006 in_row  input  N*W  one row; element k at bits [k*W +: W], element 0 at LSB.
REQ-007 in_valid  input  1  in_row valid.
REQ-008 in_ready  output  1  buffer accepts in_row this cycle.
REQ-009 out_col  output  N*W  one column; element k = row k of the block, same packing as in_row.
REQ-010 out_valid  output  1  out_col valid.
REQ-011 out_ready  input  1  consumer accepts out_col this cycle.
REQ-012 out_last  output  1  high with out_valid on the final column (index N-1) of a block.
REQ-013 level  output  2  number of full banks (0, 1 or 2).

Function
REQ-014 Storage: two banks of N rows x N*W bits each; wr_bank/rd_bank 1-bit pointers; wr_row and rd_col counters of ceil(log2 N) bits.
REQ-015 A write transfer occurs when in_valid && in_ready; in_row is stored in row wr_row of bank wr_bank, and wr_row increments.
REQ-016 On the write transfer with wr_row = N-1, bank wr_bank is marked full, wr_row wraps to 0, wr_bank toggles.
REQ-017 in_ready = !full[wr_bank] && !clear; derived from registered state only, never from out_ready.
REQ-018 out_valid = full[rd_bank] && !clear; out_col = column rd_col of bank rd_bank while out_valid, all-zero otherwise.
REQ-019 A read transfer occurs when out_valid && out_ready; rd_col increments; out_col and out_valid stay stable while out_valid && !out_ready.
REQ-020 On the read transfer with rd_col = N-1, full[rd_bank] clears, rd_col wraps to 0, rd_bank toggles.
REQ-021 Latency: a block's first column is valid the cycle after its N-th row is written.
REQ-022 A write to one bank and a read from the other in the same cycle are both performed.
REQ-023 A bank freed by a read transfer becomes writable the following cycle; with in_valid and out_ready held high, throughput is one row and one column per cycle after the first N cycles.
REQ-024 Writing the last row and reading the last column in the same cycle updates level by net zero.
REQ-025 clear: next cycle all full flags = 0, wr_row = rd_col = 0, wr_bank = rd_bank = 0; no transfer occurs in the clear cycle.

Reset
REQ-026 While reset is high: in_ready = 0, out_valid = 0, out_last = 0, out_col = 0, level = 0, and all pointers, counters and full flags = 0.
REQ-027 Reset asserted mid-block abandons the block; after release, the first accepted row is row 0 of bank 0.
REQ-028 Storage arrays are not reset; no output depends on them while out_valid = 0.

Configuration
REQ-029 Macro TPBUF_PASSTHRU_EN, when defined, adds input transpose (1 bit), sampled with each block's first read transfer and held for that block.
REQ-030 With TPBUF_PASSTHRU_EN and transpose = 0, out_col returns row rd_col unchanged; with transpose = 1, or without the macro, the transpose of REQ-018 applies.

Verification
REQ-031 N=8, W=8, rows r where element k = 8r+k, consumer always ready -> columns c carry element k = 8k+c; out_last on the 8th column; first out_valid one cycle after row 7.
REQ-032 Continuous 4 blocks with in_valid = out_ready = 1 -> in_ready never low after reset release; 32 columns out, level never exceeds 1.
REQ-033 out_ready = 0 after 16 rows written -> level = 2, in_ready = 0, out_col stable; one read cycle later in_ready stays 0; 8 reads later in_ready = 1.
REQ-034 clear asserted after 5 rows -> next cycle level = 0, out_valid = 0; new block reads back without stale data.
REQ-035 reset asserted asynchronously mid-read at rd_col = 3 -> outputs zero immediately; after release, a fresh block transposes correctly from column 0.
REQ-036 With TPBUF_PASSTHRU_EN, transpose = 0 -> out_col equals input rows in order; toggling transpose mid-block has no effect until the next block.

Source files
------------

// File: rtl/tpbuf_pingpong.sv
// rtl/tpbuf_pingpong.sv - ping-pong NxN block transpose buffer (rows in, columns out)
// Optional macro TPBUF_PASSTHRU_EN adds a per-block transpose select input.
module tpbuf_pingpong #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic [N*W-1:0] in_row,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N*W-1:0] out_col,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
`ifdef TPBUF_PASSTHRU_EN
    input  logic           transpose,
`endif
    output logic [1:0]     level
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    logic [N*W-1:0] mem [2][N];
    logic [N*W-1:0] rows_sel [N];
    logic [W-1:0]   elem [N][N];
    logic [N*W-1:0] tcol;
    logic [N*W-1:0] pcol;

    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;
    logic [1:0]    full_next;
    logic [AW-1:0] wr_row;
    logic [AW-1:0] rd_col;
    logic          wr_fire;
    logic          rd_fire;
    logic          use_t;

    // Outputs are forced quiet while reset is asserted, independent of state.
    assign in_ready  = !reset && !clear && !full[wr_bank];
    assign out_valid = !reset && !clear && full[rd_bank];
    assign out_last  = out_valid && (rd_col == LAST);
    assign level     = {1'b0, full[0]} + {1'b0, full[1]};
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_row] <= in_row;
        end
    end

    genvar k, c;
    generate
        for (k = 0; k < N; k++) begin : g_row
            assign rows_sel[k] = rd_bank ? mem[1][k] : mem[0][k];
            for (c = 0; c < N; c++) begin : g_elem
                assign elem[k][c] = rows_sel[k][c*W +: W];
            end
            assign tcol[k*W +: W] = elem[k][rd_col];
        end
    endgenerate

    assign pcol = rows_sel[rd_col];

`ifdef TPBUF_PASSTHRU_EN
    logic mode_q;

    // Column 0 follows the live input; later columns use the value latched on it.
    assign use_t = (rd_col == '0) ? transpose : mode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= 1'b1;
        end else if (clear) begin
            mode_q <= 1'b1;
        end else if (rd_fire && (rd_col == '0)) begin
            mode_q <= transpose;
        end
    end
`else
    assign use_t = 1'b1;
`endif

    assign out_col = !out_valid ? '0 : (use_t ? tcol : pcol);

    // Write and read banks always differ when both fire, so set and clear never collide.
    always_comb begin
        full_next = full;
        if (wr_fire && (wr_row == LAST)) begin
            full_next[wr_bank] = 1'b1;
        end
        if (rd_fire && (rd_col == LAST)) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else if (clear) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else begin
            full <= full_next;
            if (wr_fire) begin
                if (wr_row == LAST) begin
                    wr_row  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_col == LAST) begin
                    rd_col  <= '0;
                    rd_bank <= !rd_bank;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tpbuf_pingpong.sv
// tb/tb_tpbuf_pingpong.sv - directed bench for tpbuf_pingpong (N=8, W=8)
module tb_tpbuf_pingpong;

    localparam int N = 8;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           clear;
    logic [N*W-1:0] in_row;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] out_col;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic [1:0]     level;
`ifdef TPBUF_PASSTHRU_EN
    logic           transpose = 1'b1;
`endif

    int checks = 0;
    int errors = 0;
    int ncols;

    tpbuf_pingpong #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_row    (in_row),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef TPBUF_PASSTHRU_EN
        .transpose (transpose),
`endif
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Row r of a block with base off: element k = off + 8r + k.
    function automatic logic [63:0] row_val(input int off, input int r);
        logic [63:0] v;
        for (int k = 0; k < N; k++) v[k*8 +: 8] = 8'(off + 8*r + k);
        return v;
    endfunction

    // Column c of the same block: element k = off + 8k + c.
    function automatic logic [63:0] col_val(input int off, input int c);
        logic [63:0] v;
        for (int k = 0; k < N; k++) v[k*8 +: 8] = 8'(off + 8*k + c);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_block(input int off);
        for (int r = 0; r < N; r++) begin
            in_row   = row_val(off, r);
            in_valid = 1'b1;
            #1;
            check("wr_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        in_row   = '0;
    endtask

    task automatic read_block(input int off, input string tag);
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) begin
            #1;
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_col"}, out_col, col_val(off, c));
            check({tag, "_last"}, out_last, (c == N - 1) ? 1 : 0);
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_row    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_out_col", out_col, 0);
        check("rst_out_last", out_last, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Basic transpose, latency and out_last
        out_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            in_row   = row_val(0, r);
            in_valid = 1'b1;
            #1;
            check("b_in_ready", in_ready, 1);
            check("b_no_early_valid", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("b_latency_valid", out_valid, 1);
        check("b_level1", level, 1);
        read_block(0, "b");
        #1;
        check("b_drained_level", level, 0);
        check("b_drained_valid", out_valid, 0);

        // Four back-to-back blocks with both sides always ready
        ncols     = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 48; t++) begin
            in_valid = (t < 32);
            in_row   = (t < 32) ? row_val((t / 8) * 64, t % 8) : '0;
            #1;
            if (t < 32) check("s_in_ready", in_ready, 1);
            check("s_level_le1", (level <= 2'd1), 1);
            if (out_valid) begin
                check("s_col", out_col, col_val((ncols / 8) * 64, ncols % 8));
                check("s_last", out_last, (ncols % 8 == 7) ? 1 : 0);
                ncols++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("s_col_count", ncols, 32);

        // Backpressure: both banks fill, then drain
        out_ready = 1'b0;
        for (int t = 0; t < 16; t++) begin
            in_row   = row_val((t / 8) * 64, t % 8);
            in_valid = 1'b1;
            #1;
            check("p_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("p_level2", level, 2);
        check("p_in_ready_full", in_ready, 0);
        check("p_out_valid", out_valid, 1);
        check("p_col0", out_col, col_val(0, 0));
        tick();
        check("p_col0_stable", out_col, col_val(0, 0));
        check("p_valid_stable", out_valid, 1);
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) begin
            #1;
            check("p_col", out_col, col_val(0, c));
            tick();
            if (c == 0) check("p_in_ready_after1", in_ready, 0);
        end
        check("p_in_ready_after8", in_ready, 1);
        check("p_level_after8", level, 1);
        read_block(64, "p2");
        check("p_level_end", level, 0);

        // Synchronous clear with one full bank and a partial second bank
        out_ready = 1'b0;
        write_block(0);
        for (int r = 0; r < 5; r++) begin
            in_row   = row_val(16, r);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("c_level_before", level, 1);
        clear = 1'b1;
        #1;
        check("c_in_ready_during", in_ready, 0);
        check("c_out_valid_during", out_valid, 0);
        tick();
        clear = 1'b0;
        #1;
        check("c_level_after", level, 0);
        check("c_out_valid_after", out_valid, 0);
        check("c_in_ready_after", in_ready, 1);
        write_block(128);
        #1;
        check("c_level_new", level, 1);
        read_block(128, "c");

        // Asynchronous reset mid-read, with a partial block in the other bank
        out_ready = 1'b0;
        write_block(32);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_row   = row_val(96, c);
            in_valid = 1'b1;
            #1;
            check("r_col", out_col, col_val(32, c));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("r_col3_before", out_col, col_val(32, 3));
        #2;
        reset = 1'b1;
        #1;
        check("r_async_out_valid", out_valid, 0);
        check("r_async_out_col", out_col, 0);
        check("r_async_out_last", out_last, 0);
        check("r_async_in_ready", in_ready, 0);
        check("r_async_level", level, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("r_rel_level", level, 0);
        check("r_rel_out_valid", out_valid, 0);
        write_block(160);
        #1;
        check("r_fresh_level", level, 1);
        read_block(160, "r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
